// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient engine and the edge-map writer.
package sobel_pkg;

    typedef enum logic [1:0] {
        GX_ONLY = 2'd0,
        GY_ONLY = 2'd1,
        L1      = 2'd2,
        LMAX    = 2'd3
    } grad_mode_t;

    // Clip an unsigned magnitude to the largest value representable in out_w bits.
    function automatic logic [31:0] sat_mag(input logic [31:0] val, input int unsigned out_w);
        logic [31:0] max_v;
        max_v = (32'd1 << out_w) - 32'd1;
        return (val > max_v) ? max_v : val;
    endfunction

endpackage

// File: rtl/sobel_kernel_comb.sv
// Combinational Sobel kernel: weights the six row/column differences into signed gx and gy.
module sobel_kernel_comb #(
    parameter int unsigned PIX_W = 8
) (
    input  logic signed [PIX_W:0]   dx_top_i,
    input  logic signed [PIX_W:0]   dx_mid_i,
    input  logic signed [PIX_W:0]   dx_bot_i,
    input  logic signed [PIX_W:0]   dy_left_i,
    input  logic signed [PIX_W:0]   dy_mid_i,
    input  logic signed [PIX_W:0]   dy_right_i,
    output logic signed [PIX_W+2:0] gx_o,
    output logic signed [PIX_W+2:0] gy_o
);

    function automatic logic signed [PIX_W+2:0] sext(input logic signed [PIX_W:0] v);
        return {{2{v[PIX_W]}}, v};
    endfunction

    // Centre row/column carries weight 2; PIX_W+3 bits cannot overflow.
    assign gx_o = sext(dx_top_i) + (sext(dx_mid_i) <<< 1) + sext(dx_bot_i);
    assign gy_o = sext(dy_left_i) + (sext(dy_mid_i) <<< 1) + sext(dy_right_i);

endmodule

// File: rtl/sobel_gradient_pipe.sv
// Three-stage streaming Sobel engine: differences, gradients, then magnitude/edge outputs,
// with a single global advance enable for backpressure.
module sobel_gradient_pipe
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [9*PIX_W-1:0]      win_i,
    input  grad_mode_t              mode_i,
    input  logic [OUT_W-1:0]        thresh_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [PIX_W+2:0] gx_o,
    output logic signed [PIX_W+2:0] gy_o,
    output logic [OUT_W-1:0]        mag_o,
    output logic                    edge_o,
    output logic [CNT_W-1:0]        pix_count_o
);

    localparam int unsigned DW = PIX_W + 1;
    localparam int unsigned GW = PIX_W + 3;

    logic                 en;
    logic [PIX_W-1:0]     pix [9];
    logic signed [DW-1:0] diff_d [6];
    logic signed [DW-1:0] diff_q [6];
    logic                 s1_valid_q, s2_valid_q, out_valid_q;
    grad_mode_t           s1_mode_q, s2_mode_q;
    logic [OUT_W-1:0]     s1_thresh_q, s2_thresh_q;
    logic signed [GW-1:0] gx_d, gy_d, s2_gx_q, s2_gy_q, gx_q, gy_q;
    logic [GW-1:0]        abs_x, abs_y;
    logic [GW:0]          mag_raw;
    logic [OUT_W-1:0]     mag_d, mag_q;
    logic                 edge_d, edge_q;
    logic [CNT_W-1:0]     cnt_q;

    function automatic logic signed [DW-1:0] pdiff(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
        return v[GW-1] ? -v : v;
    endfunction

    assign en         = !out_valid_q || out_ready_i;
    assign in_ready_o = en;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            pix[i] = win_i[i*PIX_W +: PIX_W];
        end
        diff_d[0] = pdiff(pix[2], pix[0]);
        diff_d[1] = pdiff(pix[5], pix[3]);
        diff_d[2] = pdiff(pix[8], pix[6]);
        diff_d[3] = pdiff(pix[6], pix[0]);
        diff_d[4] = pdiff(pix[7], pix[1]);
        diff_d[5] = pdiff(pix[8], pix[2]);
    end

    sobel_kernel_comb #(
        .PIX_W(PIX_W)
    ) u_kernel (
        .dx_top_i  (diff_q[0]),
        .dx_mid_i  (diff_q[1]),
        .dx_bot_i  (diff_q[2]),
        .dy_left_i (diff_q[3]),
        .dy_mid_i  (diff_q[4]),
        .dy_right_i(diff_q[5]),
        .gx_o      (gx_d),
        .gy_o      (gy_d)
    );

    always_comb begin
        abs_x   = abs_val(s2_gx_q);
        abs_y   = abs_val(s2_gy_q);
        mag_raw = '0;
        unique case (s2_mode_q)
            GX_ONLY: mag_raw = {1'b0, abs_x};
            GY_ONLY: mag_raw = {1'b0, abs_y};
            L1:      mag_raw = {1'b0, abs_x} + {1'b0, abs_y};
            LMAX:    mag_raw = (abs_x > abs_y) ? {1'b0, abs_x} : {1'b0, abs_y};
            default: mag_raw = '0;
        endcase
        mag_d  = OUT_W'(sat_mag(32'(mag_raw), OUT_W));
        edge_d = mag_d > s2_thresh_q;
    end

    // clear only kills valids; stale data behind a zero valid is harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clear_i) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= in_valid_i;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 6; i++) begin
                diff_q[i] <= '0;
            end
            s1_mode_q   <= GX_ONLY;
            s1_thresh_q <= '0;
            s2_gx_q     <= '0;
            s2_gy_q     <= '0;
            s2_mode_q   <= GX_ONLY;
            s2_thresh_q <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            mag_q       <= '0;
            edge_q      <= 1'b0;
        end else if (en) begin
            diff_q      <= diff_d;
            s1_mode_q   <= mode_i;
            s1_thresh_q <= thresh_i;
            s2_gx_q     <= gx_d;
            s2_gy_q     <= gy_d;
            s2_mode_q   <= s1_mode_q;
            s2_thresh_q <= s1_thresh_q;
            gx_q        <= s2_gx_q;
            gy_q        <= s2_gy_q;
            mag_q       <= mag_d;
            edge_q      <= edge_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (out_valid_q && out_ready_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid_o = out_valid_q;
    assign gx_o        = gx_q;
    assign gy_o        = gy_q;
    assign mag_o       = mag_q;
    assign edge_o      = edge_q;
    assign pix_count_o = cnt_q;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Randomized scoreboard bench for sobel_gradient_pipe plus directed corner cases.
module tb_sobel_gradient_pipe;
    import sobel_pkg::*;

    localparam int PIX_W = 8;
    localparam int OUT_W = 8;
    localparam int CNT_W = 20;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic [9*PIX_W-1:0]      win;
    grad_mode_t              mode;
    logic [OUT_W-1:0]        thresh;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [PIX_W+2:0] gx;
    logic signed [PIX_W+2:0] gy;
    logic [OUT_W-1:0]        mag;
    logic                    edge_out;
    logic [CNT_W-1:0]        pix_count;

    typedef struct {
        int gx;
        int gy;
        int mag;
        int edge_f;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_model = 0;

    always #5 clk = ~clk;

    sobel_gradient_pipe #(
        .PIX_W(PIX_W),
        .OUT_W(OUT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .win_i      (win),
        .mode_i     (mode),
        .thresh_i   (thresh),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .gx_o       (gx),
        .gy_o       (gy),
        .mag_o      (mag),
        .edge_o     (edge_out),
        .pix_count_o(pix_count)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic res_t ref_model(input logic [71:0] w, input logic [1:0] m, input int th);
        int   p[9];
        int   ax, ay;
        res_t r;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i*8 +: 8]);
        r.gx = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
        r.gy = (p[6] - p[0]) + 2 * (p[7] - p[1]) + (p[8] - p[2]);
        ax = (r.gx < 0) ? -r.gx : r.gx;
        ay = (r.gy < 0) ? -r.gy : r.gy;
        case (m)
            2'd0:    r.mag = ax;
            2'd1:    r.mag = ay;
            2'd2:    r.mag = ax + ay;
            default: r.mag = (ax > ay) ? ax : ay;
        endcase
        if (r.mag > 255) r.mag = 255;
        r.edge_f = (r.mag > th) ? 1 : 0;
        return r;
    endfunction

    // Scoreboard: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        res_t r;
        if (!rst_n || clear) begin
            exp_q.delete();
            cnt_model = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_out", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check_eq("sb_gx", int'(gx), r.gx);
                    check_eq("sb_gy", int'(gy), r.gy);
                    check_eq("sb_mag", int'(mag), r.mag);
                    check_eq("sb_edge", int'(edge_out), r.edge_f);
                end
                cnt_model = (cnt_model + 1) & ((1 << CNT_W) - 1);
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(win, mode, int'(thresh)));
        end
    end

    task automatic send(input logic [71:0] w, input grad_mode_t m, input logic [7:0] th);
        bit acc;
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        win      = w;
        mode     = m;
        thresh   = th;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check_eq("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("drain_done", int'(exp_q.size() == 0), 1);
        check_eq("pix_count_model", int'(pix_count), cnt_model);
    endtask

    function automatic logic [71:0] col_win(input int a, input int b, input int c,
                                            input logic [7:0] v);
        logic [71:0] w;
        w = '0;
        w[a*8 +: 8] = v;
        w[b*8 +: 8] = v;
        w[c*8 +: 8] = v;
        return w;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [95:0] t;
        logic [71:0] w;
        int          kind;
        logic [7:0]  u;
        kind = $urandom_range(0, 3);
        t    = {$urandom(), $urandom(), $urandom()};
        w    = t[71:0];
        u    = w[7:0];
        for (int i = 0; i < 9; i++) begin
            if (kind == 0) w[i*8 +: 8] = u;
            else if (kind == 1) w[i*8 +: 8] = w[i*8] ? 8'd255 : 8'd0;
        end
        return w;
    endfunction

    // Single window with an exact-latency check and hand-derived expected values.
    task automatic directed(input string tag, input logic [71:0] w, input grad_mode_t m,
                            input logic [7:0] th, input int egx, input int egy, input int emag,
                            input int eedge);
        int lat;
        send(w, m, th);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 3);
        check_eq({tag, "_gx"}, int'(gx), egx);
        check_eq({tag, "_gy"}, int'(gy), egy);
        check_eq({tag, "_mag"}, int'(mag), emag);
        check_eq({tag, "_edge"}, int'(edge_out), eedge);
        @(posedge clk);
        #1;
    endtask

    bit          rnd_run;
    logic [71:0] uni;

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        win       = '0;
        mode      = GX_ONLY;
        thresh    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_pix_count", int'(pix_count), 0);
        check_eq("rst_gx", int'(gx), 0);
        check_eq("rst_mag", int'(mag), 0);
        check_eq("rst_edge", int'(edge_out), 0);

        directed("right_col", col_win(2, 5, 8, 8'd255), L1, 8'd100, 1020, 0, 255, 1);
        directed("left_col", col_win(0, 3, 6, 8'd255), GX_ONLY, 8'd0, -1020, 0, 255, 1);
        directed("bottom_row", col_win(6, 7, 8, 8'd10), GY_ONLY, 8'd50, 0, 40, 40, 0);
        uni = '0;
        for (int i = 0; i < 9; i++) uni[i*8 +: 8] = 8'd100;
        directed("uniform", uni, LMAX, 8'd0, 0, 0, 0, 0);
        drain();

        // Backpressure: six windows, first result stalled for five cycles.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(rand_win(), grad_mode_t'($urandom_range(0, 3)), 8'($urandom));
                end
            end
            begin
                int          n;
                logic [10:0] hold_gx;
                logic [7:0]  hold_mag;
                n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check_eq("stall_first_seen", int'(out_valid), 1);
                out_ready = 1'b0;
                hold_gx   = gx;
                hold_mag  = mag;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check_eq("stall_in_ready", int'(in_ready), 0);
                    check_eq("stall_valid_hold", int'(out_valid), 1);
                    check_eq("stall_gx_hold", int'(gx), int'($signed(hold_gx)));
                    check_eq("stall_mag_hold", int'(mag), int'(hold_mag));
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("stall_pix_count", int'(pix_count), 6);

        // Random streaming with random backpressure.
        rnd_run = 1'b1;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    send(rand_win(), grad_mode_t'($urandom_range(0, 3)), 8'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Clear with three windows in flight.
        for (int k = 0; k < 3; k++) send(rand_win(), L1, 8'd10);
        out_ready = 1'b0;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        out_ready = 1'b1;
        check_eq("clear_out_valid", int'(out_valid), 0);
        check_eq("clear_pix_count", int'(pix_count), 0);
        repeat (6) begin
            @(posedge clk);
            #1;
            check_eq("clear_no_stale", int'(out_valid), 0);
        end

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 4; k++) send(rand_win(), LMAX, 8'd20);
        check_eq("prerst_out_valid", int'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", int'(out_valid), 0);
        check_eq("arst_pix_count", int'(pix_count), 0);
        #13;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check_eq("arst_no_partial", int'(out_valid), 0);
        end
        directed("post_rst", col_win(6, 7, 8, 8'd10), GY_ONLY, 8'd39, 0, 40, 40, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
